maze_move_controller: RTL and testbench

Input sequencer for the maze state machine. Conditions the three raw push-buttons (2-flop sync, per-button debounce, rising-edge detect) and arbitrates them into single-cycle, one-hot move pulses. Enforces a hold-off between moves, counts accepted moves, flags goal arrival from the maze state, and issues a maze reset on a three-button abort chord.

---
 rtl/maze_move_controller.sv | 159 +++++++++++++++
 tb/tb_maze_move_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_move_controller.sv
// Button front-end for the maze: sync, debounce and edge-detect three push-buttons,
// then arbitrate them into one-hot move pulses with hold-off, move counting, goal and abort.
module maze_move_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int MOVE_CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  BTN_LEFT,
  input  logic                  BTN_CENTRE,
  input  logic                  BTN_RIGHT,
  input  logic [2:0]            STATE_IN,
  output logic                  MOVE_LEFT,
  output logic                  MOVE_CENTRE,
  output logic                  MOVE_RIGHT,
  output logic                  MAZE_RESET,
  output logic [MOVE_CNT_W-1:0] MOVE_COUNT,
  output logic                  GOAL,
  output logic                  BUSY
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES);
  localparam logic [DB_W-1:0]       DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0]       HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [MOVE_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]            GOAL_STATE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Bit order everywhere: [0] left, [1] centre, [2] right.
  logic [2:0]            btn_raw;
  logic [2:0]            sync_q1, sync_q2;
  logic [2:0]            deb_q, deb_prev_q;
  logic [DB_W-1:0]       db_cnt_q [3];
  logic [2:0]            rise;
  logic [2:0]            pending_q;
  logic [2:0]            winner;
  logic [2:0]            sel_q;
  logic [HO_W-1:0]       hold_cnt_q;
  logic                  hold_done;
  logic [MOVE_CNT_W-1:0] move_cnt_q;
  logic                  chord_seen_q;
  logic                  abort;
  logic                  maze_reset_q;
  logic                  issue_fire;
  state_t                state_q, state_d;

  assign btn_raw = {BTN_RIGHT, BTN_CENTRE, BTN_LEFT};

  // NOTE: every flop here, including the small debounce counter array, is cleared by the
  // async reset; these are registers, not a RAM, so a reset costs nothing and avoids X.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q1    <= '0;
      sync_q2    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the sync chain a true two-stage shift.
      sync_q1    <= btn_raw;
      sync_q2    <= sync_q1;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= ~deb_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise      = deb_q & ~deb_prev_q;
  assign abort     = (&deb_q) & ~chord_seen_q;
  assign hold_done = (hold_cnt_q == '0);

  // Fixed priority: centre, then left, then right.
  always_comb begin
    // NOTE: a default on entry keeps this combinational block from inferring a latch.
    winner = 3'b000;
    if (pending_q[1])      winner = 3'b010;
    else if (pending_q[0]) winner = 3'b001;
    else if (pending_q[2]) winner = 3'b100;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_WAIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (STATE_IN == GOAL_STATE) state_d = S_DONE;
          else if (|pending_q)        state_d = S_ISSUE;
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (hold_done) state_d = (STATE_IN == GOAL_STATE) ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (STATE_IN != GOAL_STATE) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_fire  = (state_q == S_ISSUE) && !abort;
    MOVE_LEFT   = issue_fire & sel_q[0];
    MOVE_CENTRE = issue_fire & sel_q[1];
    MOVE_RIGHT  = issue_fire & sel_q[2];
    MAZE_RESET  = maze_reset_q;
    MOVE_COUNT  = move_cnt_q;
    GOAL        = (state_q == S_DONE);
    BUSY        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q    <= '0;
      sel_q        <= '0;
      hold_cnt_q   <= '0;
      move_cnt_q   <= '0;
      chord_seen_q <= 1'b0;
      maze_reset_q <= 1'b0;
    end else begin
      maze_reset_q <= abort;

      // Edges only collect while idle; losers and edges in ISSUE/WAIT/DONE are dropped.
      if (abort || state_q != S_IDLE) pending_q <= '0;
      else                            pending_q <= pending_q | rise;

      if (state_q == S_IDLE && state_d == S_ISSUE) sel_q <= winner;

      if (abort || state_q == S_ISSUE)      hold_cnt_q <= HO_LOAD;
      else if (state_q == S_WAIT && !hold_done) hold_cnt_q <= hold_cnt_q - HO_W'(1);

      if (abort)                                   move_cnt_q <= '0;
      else if (issue_fire && move_cnt_q != CNT_MAX) move_cnt_q <= move_cnt_q + MOVE_CNT_W'(1);

      // The chord re-arms only once every debounced level has dropped.
      if (abort)              chord_seen_q <= 1'b1;
      else if (deb_q == 3'b000) chord_seen_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maze_move_controller.sv
// Directed bench for maze_move_controller: a vector table for press/bounce/arbitration/goal
// behaviour plus hand-written sequences for saturation, abort chord and mid-operation reset.
module tb_maze_move_controller;

  localparam logic [2:0] N = 3'b000;
  localparam logic [2:0] L = 3'b001;
  localparam logic [2:0] C = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] A = 3'b111;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [2:0] btn;
  logic [2:0] st;
  logic       MOVE_LEFT, MOVE_CENTRE, MOVE_RIGHT, MAZE_RESET, GOAL, BUSY;
  logic [7:0] MOVE_COUNT;
  logic [2:0] move;
  logic [13:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  maze_move_controller #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (4),
    .MOVE_CNT_W     (8)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .BTN_LEFT   (btn[0]),
    .BTN_CENTRE (btn[1]),
    .BTN_RIGHT  (btn[2]),
    .STATE_IN   (st),
    .MOVE_LEFT  (MOVE_LEFT),
    .MOVE_CENTRE(MOVE_CENTRE),
    .MOVE_RIGHT (MOVE_RIGHT),
    .MAZE_RESET (MAZE_RESET),
    .MOVE_COUNT (MOVE_COUNT),
    .GOAL       (GOAL),
    .BUSY       (BUSY)
  );

  assign move = {MOVE_RIGHT, MOVE_CENTRE, MOVE_LEFT};
  assign obs  = {move, MAZE_RESET, GOAL, BUSY, MOVE_COUNT};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: inputs driven after this returns are sampled on the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_release(input logic [2:0] b, output int moves);
    moves = 0;
    btn = b;
    repeat (8) begin tick(); if (move != 3'b000) moves++; end
    btn = N;
    repeat (8) begin tick(); if (move != 3'b000) moves++; end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    btn = N;
    st  = 3'd0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  typedef struct {
    string      name;
    int         cycles;
    logic [2:0] btn;
    logic [2:0] st;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input int cycles, input logic [2:0] b,
                              input logic [2:0] s, input logic [2:0] mv, input logic mr,
                              input logic gl, input logic bs, input logic [7:0] cnt);
    vec_t v;
    v.name   = name;
    v.cycles = cycles;
    v.btn    = b;
    v.st     = s;
    v.exp    = {mv, mr, gl, bs, cnt};
    vecs.push_back(v);
  endfunction

  initial begin
    int stray;
    int m;
    int total;
    int mr_n;
    int mr_first;
    int mv_n;

    // Each record holds its inputs for 'cycles' edges; outputs are compared on the last one,
    // and no move/maze-reset pulse may appear on the earlier ones.
    add("clean_pre",   7, C, 3'd0, N, 0, 0, 0, 8'd0);
    add("clean_pulse", 1, C, 3'd0, C, 0, 0, 1, 8'd0);
    add("clean_cnt",   1, C, 3'd0, N, 0, 0, 1, 8'd1);
    add("clean_wait",  3, C, 3'd0, N, 0, 0, 1, 8'd1);
    add("clean_idle",  1, C, 3'd0, N, 0, 0, 0, 8'd1);
    add("clean_hold",  7, C, 3'd0, N, 0, 0, 0, 8'd1);
    add("clean_rel",  10, N, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_a",       2, L, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_b",       2, N, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_c",       2, L, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_d",       2, N, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_hold",    7, L, 3'd0, N, 0, 0, 0, 8'd1);
    add("bnc_pulse",   1, L, 3'd0, L, 0, 0, 1, 8'd1);
    add("bnc_cnt",     1, L, 3'd0, N, 0, 0, 1, 8'd2);
    add("bnc_settle", 10, L, 3'd0, N, 0, 0, 0, 8'd2);
    add("bnc_rel",    10, N, 3'd0, N, 0, 0, 0, 8'd2);
    add("sim_pre",     7, L|R, 3'd0, N, 0, 0, 0, 8'd2);
    add("sim_pulse",   1, L|R, 3'd0, L, 0, 0, 1, 8'd2);
    add("sim_cnt",     1, L|R, 3'd0, N, 0, 0, 1, 8'd3);
    add("sim_hold",   10, L|R, 3'd0, N, 0, 0, 0, 8'd3);
    add("sim_rel",    10, N, 3'd0, N, 0, 0, 0, 8'd3);
    add("r_pre",       7, R, 3'd0, N, 0, 0, 0, 8'd3);
    add("r_pulse",     1, R, 3'd0, R, 0, 0, 1, 8'd3);
    add("r_cnt",       1, R, 3'd0, N, 0, 0, 1, 8'd4);
    add("r_hold",      5, R, 3'd0, N, 0, 0, 0, 8'd4);
    add("r_rel",      10, N, 3'd0, N, 0, 0, 0, 8'd4);
    add("goal_in",     1, N, 3'd7, N, 0, 1, 0, 8'd4);
    add("goal_press", 14, C, 3'd7, N, 0, 1, 0, 8'd4);
    add("goal_out",    1, C, 3'd0, N, 0, 0, 0, 8'd4);
    add("goal_after", 10, C, 3'd0, N, 0, 0, 0, 8'd4);
    add("goal_rel",   10, N, 3'd0, N, 0, 0, 0, 8'd4);

    // Reset held with buttons toggling and the goal state presented.
    RESET_N = 1'b0;
    btn = N;
    st  = 3'd7;
    #2;
    for (int c = 0; c < 6; c++) begin
      btn = (c % 2 == 0) ? A : N;
      tick();
      check("reset_hold", obs, 14'd0);
    end
    btn = N;
    st  = 3'd0;
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("reset_release", obs, 14'd0);
    end

    foreach (vecs[i]) begin
      stray = 0;
      btn = vecs[i].btn;
      st  = vecs[i].st;
      for (int k = 1; k <= vecs[i].cycles; k++) begin
        tick();
        if (k < vecs[i].cycles && (move != 3'b000 || MAZE_RESET)) stray++;
      end
      check({vecs[i].name, "_stray"}, stray, 0);
      check(vecs[i].name, obs, vecs[i].exp);
    end

    // Saturation: 255 presses fill the counter, one more must not wrap it.
    do_reset();
    check("sat_start", MOVE_COUNT, 8'd0);
    total = 0;
    for (int j = 0; j < 255; j++) begin
      press_release(C, m);
      total += m;
    end
    check("sat_moves", total, 255);
    check("sat_full", MOVE_COUNT, 8'd255);
    press_release(C, m);
    check("sat_extra_move", m, 1);
    check("sat_hold", MOVE_COUNT, 8'd255);

    // Abort chord from IDLE: debounced levels rise together in cycle 6, MAZE_RESET in cycle 7.
    mr_n = 0; mr_first = -1; mv_n = 0;
    btn = A;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (MAZE_RESET) begin mr_n++; if (mr_first < 0) mr_first = c; end
      if (move != 3'b000) mv_n++;
      if (c == 7) begin
        check("abort_count_clear", MOVE_COUNT, 8'd0);
        check("abort_busy", BUSY, 1'b1);
      end
    end
    check("abort_pulses", mr_n, 1);
    check("abort_cycle", mr_first, 7);
    check("abort_no_move", mv_n, 0);
    btn = N;
    repeat (12) tick();

    press_release(C, m);
    check("post_abort_move", m, 1);
    check("post_abort_count", MOVE_COUNT, 8'd1);

    // Chord completes in the ISSUE cycle of a centre press: abort wins, no move.
    mr_n = 0; mr_first = -1; mv_n = 0;
    btn = C;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) btn = A;
      if (MAZE_RESET) begin mr_n++; if (mr_first < 0) mr_first = c; end
      if (move != 3'b000) mv_n++;
    end
    check("collide_pulses", mr_n, 1);
    check("collide_cycle", mr_first, 9);
    check("collide_no_move", mv_n, 0);
    check("collide_count", MOVE_COUNT, 8'd0);
    btn = N;
    repeat (12) tick();

    // Asynchronous reset while in WAIT.
    btn = C;
    repeat (10) tick();
    check("mid_busy", BUSY, 1'b1);
    check("mid_count", MOVE_COUNT, 8'd1);
    RESET_N = 1'b0;
    #1;
    check("mid_reset_async", obs, 14'd0);
    btn = N;
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    check("mid_reset_after", obs, 14'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
